// File: rtl/jt7759_pkg.sv
// Shared definitions for the jt7759 sample-ROM responder: FSM states,
// default ROM byte-address width and the byte-lane selector.
package jt7759_pkg;

    localparam int ROM_AW = 17;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_PREFETCH = 2'd2
    } state_t;

    // Words are little-endian: odd byte addresses take the upper lane.
    function automatic logic [7:0] byte_sel(input logic [15:0] word, input logic odd);
        return odd ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/jt7759_romrsp_cache.sv
// Two-line word cache for jt7759_romrsp: tag compare, LRU victim and flush.
// Next-line probe outputs exist only with JT7759_ROMRSP_PREFETCH_EN defined.
module jt7759_romrsp_cache import jt7759_pkg::*; #(
    parameter int AW = ROM_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          lookup_en,
    input  logic [AW-2:0] lookup_tag,
    output logic          hit,
    output logic [15:0]   hit_word,
`ifdef JT7759_ROMRSP_PREFETCH_EN
    output logic          next_miss,
    output logic [AW-2:0] next_tag,
`endif
    input  logic          fill_en,
    input  logic [AW-2:0] fill_tag,
    input  logic [15:0]   fill_word
);
    logic [1:0]    valid;
    logic [AW-2:0] tag  [2];
    logic [15:0]   word [2];
    logic          mru;
    logic          victim;
    logic [1:0]    hit_line;

    assign victim      = ~mru;
    assign hit_line[0] = valid[0] && (tag[0] == lookup_tag);
    assign hit_line[1] = valid[1] && (tag[1] == lookup_tag);
    assign hit         = |hit_line;
    assign hit_word    = hit_line[1] ? word[1] : word[0];

`ifdef JT7759_ROMRSP_PREFETCH_EN
    localparam logic [AW-2:0] TAG_ONE = {{(AW-2){1'b0}}, 1'b1};
    logic [1:0] next_line;

    // Tag arithmetic wraps naturally at the word-address width.
    assign next_tag     = tag[mru] + TAG_ONE;
    assign next_line[0] = valid[0] && (tag[0] == next_tag);
    assign next_line[1] = valid[1] && (tag[1] == next_tag);
    assign next_miss    = valid[mru] && !(|next_line);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid   <= '0;
            mru     <= 1'b0;
            tag[0]  <= '0;
            tag[1]  <= '0;
            word[0] <= '0;
            word[1] <= '0;
        end else begin
            // Flush outranks a fill landing in the same cycle.
            if (flush) begin
                valid <= '0;
            end else if (fill_en) begin
                valid[victim] <= 1'b1;
                tag[victim]   <= fill_tag;
                word[victim]  <= fill_word;
            end
            if (lookup_en && hit) begin
                mru <= hit_line[1];
            end
        end
    end

endmodule

// File: rtl/jt7759_romrsp.sv
// jt7759 sample-ROM responder: byte-wide rom_cs/rom_ok port served from a
// 16-bit word memory through a two-line cache. Optional JT7759_ROMRSP_PREFETCH_EN.
module jt7759_romrsp import jt7759_pkg::*; #(
    parameter int AW = ROM_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rom_cs,
    input  logic [AW-1:0] rom_addr,
    output logic [7:0]    rom_data,
    output logic          rom_ok,
    input  logic          flush,
    output logic          mem_req,
    output logic [AW-2:0] mem_addr,
    input  logic          mem_ack,
    input  logic [15:0]   mem_data
);
    state_t        state;
    logic          discard;
    logic          ok_q;
    logic [AW-1:0] served_addr;
    logic          hit;
    logic [15:0]   hit_word;
    logic          fill_en;
    logic [AW-2:0] req_tag;
`ifdef JT7759_ROMRSP_PREFETCH_EN
    logic          next_miss;
    logic [AW-2:0] next_tag;
`endif

    assign req_tag = rom_addr[AW-1:1];
    assign fill_en = (state != ST_IDLE) && mem_ack && !discard;
    // Gated so a stale ok never survives an address change or rom_cs drop.
    assign rom_ok  = ok_q && rom_cs && (rom_addr == served_addr);

    jt7759_romrsp_cache #(.AW(AW)) u_cache (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .lookup_en  (rom_cs),
        .lookup_tag (req_tag),
        .hit        (hit),
        .hit_word   (hit_word),
`ifdef JT7759_ROMRSP_PREFETCH_EN
        .next_miss  (next_miss),
        .next_tag   (next_tag),
`endif
        .fill_en    (fill_en),
        .fill_tag   (mem_addr),
        .fill_word  (mem_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ok_q        <= 1'b0;
            rom_data    <= '0;
            served_addr <= '0;
        end else begin
            ok_q <= rom_cs && hit && !flush;
            if (rom_cs && hit) begin
                rom_data    <= byte_sel(hit_word, rom_addr[0]);
                served_addr <= rom_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            discard  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rom_cs && !hit) begin
                        state    <= ST_FETCH;
                        mem_req  <= 1'b1;
                        mem_addr <= req_tag;
                        discard  <= 1'b0;
                    end
`ifdef JT7759_ROMRSP_PREFETCH_EN
                    else if (next_miss && !flush) begin
                        state    <= ST_PREFETCH;
                        mem_req  <= 1'b1;
                        mem_addr <= next_tag;
                        discard  <= 1'b0;
                    end
`endif
                end
                // Fetches cannot be cancelled; a flush only poisons the fill.
                ST_FETCH, ST_PREFETCH: begin
                    if (flush) begin
                        discard <= 1'b1;
                    end
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/jt7759_romrsp.md
# jt7759_romrsp

ROM responder for the jt7759 sample-ROM port. It serves the controller's byte-wide `rom_cs`/`rom_addr` → `rom_data`/`rom_ok` handshake from a 16-bit word memory (SDRAM/BRAM arbiter) using a `mem_req`/`mem_ack` handshake. It sits between the jt7759 controller and the system memory arbiter. A two-line word cache makes sequential nibble streaming and header reads hit without a memory round trip.

## Interface
Parameters:
- `AW`, 17: byte-address width of `rom_addr`; the word address is `AW-1` bits.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `rom_cs`  in  1  controller read request, level
- `rom_addr`  in  AW  byte address; bit 0 selects the byte (0 = low byte)
- `rom_data`  out  8  byte for `rom_addr`
- `rom_ok`  out  1  `rom_data` valid for the current `rom_addr`
- `flush`  in  1  one-cycle pulse; invalidates the cache
- `mem_req`  out  1  word request, level; held until ack
- `mem_addr`  out  AW-1  word address
- `mem_ack`  in  1  one-cycle pulse; `mem_data` is valid in the same cycle
- `mem_data`  in  16  word data, little-endian

## Operation
- Cache holds two lines, L0 and L1. Each line has `valid`, a tag (word address) and 16 data bits.
- **Hit:** `rom_cs` is high and the tag `rom_addr[AW-1:1]` matches a valid line. The responder registers `rom_data` (byte chosen by `rom_addr[0]`) and `served_addr`, and sets `ok_q`.
- `rom_ok = ok_q & rom_cs & (rom_addr == served_addr)`. This is combinational gating, so a stale ok is never visible after an address change or a `rom_cs` drop.
- FSM states:
  - **IDLE**
    - Demand miss → FETCH, with `mem_addr` = requested tag and `mem_req` = 1.
    - Otherwise, with `JT7759_ROMRSP_PREFETCH_EN`, a missing next line → PREFETCH.
  - **FETCH**
    - On `mem_ack`, write the victim line (the line not most recently hit), drop `mem_req`, go to IDLE.
    - The address is re-evaluated in IDLE, so a request that changed mid-fetch simply misses again.
  - **PREFETCH**
    - Same as FETCH, but the target is tag+1 of the most recently hit line.
    - A demand miss arriving mid-prefetch waits for the ack, then is serviced from IDLE.
- Fetches cannot be cancelled. `mem_req` stays high until `mem_ack`, and `mem_addr` is stable while `mem_req` is high.
- **Flush:** clears both `valid` bits and `ok_q` in the next cycle.
  - A flush during FETCH/PREFETCH marks the in-flight fill as discarded. The returning word is dropped, not written.
- **Tag wrap:** word 0xFFFF + 1 = 0x0000 (modulo 2^(AW-1)).
- **Simultaneous `flush` and hit in one cycle:** flush wins; `ok_q` = 0.
- **Reset mid-operation:** all state returns to reset values. An outstanding memory transaction is abandoned, and the arbiter is reset by the same `rst`.

## Timing
- Reset values: `rom_ok` 0, `rom_data` 0, `mem_req` 0, `mem_addr` 0, both lines invalid, FSM IDLE.
- Hit latency: `rom_ok` rises 1 cycle after `rom_cs`/`rom_addr` settle.
- Miss latency: `mem_req` rises 1 cycle after the miss. The line is written on the `mem_ack` cycle. `rom_ok` rises 2 cycles after `mem_ack`: one cycle to fill, one to register the hit.
- `rom_ok` falls combinationally on a `rom_cs` drop or an address change. The controller's one-cycle `rom_cs` pulse-low is therefore always seen.
- Prefetch request issues no earlier than 1 cycle after a hit in IDLE.

## Configuration
- `JT7759_ROMRSP_PREFETCH_EN` defined:
  - PREFETCH state is present.
  - After any hit, the line for tag+1 is fetched into the victim slot if not already cached.
- `JT7759_ROMRSP_PREFETCH_EN` undefined:
  - PREFETCH state is absent.
  - Only demand misses generate `mem_req`; behaviour is otherwise identical.

## Structure
- Shared package `jt7759_pkg`: FSM state localparams (IDLE, FETCH, PREFETCH) and the default ROM byte-address width 17.
- Sub-module `jt7759_romrsp_cache` holds the two line registers, hit compare, victim/LRU bit and invalidate logic. The top holds the FSM and memory handshake.

## Test plan
- **Cold read:** `rom_cs`=1, `rom_addr`=0x00003 → `mem_req`, `mem_addr`=0x0001. Ack with `mem_data`=0x69A5 → `rom_data`=0x69, `rom_ok` 2 cycles after ack.
- **Same-word hit:** `rom_addr` 0x00003→0x00002 → `rom_ok` low the same cycle, then 0xA5 with `rom_ok`=1 one cycle later, and no `mem_req`.
- **Sequential stream with prefetch on:** reads 0x00100..0x0010F with a 4-cycle ack latency → after the first miss, no demand miss stalls. `mem_addr` sequence is 0x0080, 0x0081, ….
- **Address change mid-fetch:** miss on 0x00200, then `rom_addr`→0x00400 before ack → first fill completes, then `mem_addr`=0x0200 is requested with `rom_ok` kept low, and data for 0x00400 is returned.
- **Flush during fetch:** `flush` pulse between `mem_req` and `mem_ack` for 0x00010 → word discarded, a new request for 0x0008 is issued, and `rom_ok` stays 0 until the new ack.
- **Wrap:** hit at 0x1FFFF with prefetch on → prefetch `mem_addr`=0x0000. Reset asserted mid-fetch → `mem_req`=0, `rom_ok`=0 immediately.
